err_campaign_sequencer: RTL and testbench

ERR_CAMPAIGN_SEQUENCER -- requirements
Module: err_campaign_sequencer

---
 rtl/err_campaign_sequencer.sv | 146 ++++++++++++++
 tb/tb_err_campaign_sequencer.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/err_campaign_sequencer.sv
// Error-injection campaign sequencer: sweeps an error-control index from first to
// last, holding err_en high for on_cycles per index with an optional quiet gap.
module err_campaign_sequencer #(
    parameter int unsigned CTRLW = 8,
    parameter int unsigned CNTW  = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CTRLW-1:0] first_ctrl,
    input  logic [CTRLW-1:0] last_ctrl,
    input  logic [CNTW-1:0]  on_cycles,
    input  logic [CNTW-1:0]  off_cycles,
    output logic             err_en,
    output logic [CTRLW-1:0] err_ctrl,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic             cfg_err
);

    typedef enum logic [1:0] {StIdle, StInject, StGap} state_e;

    state_e           state_q, state_d;
    logic [CNTW-1:0]  cnt_q, cnt_d;
    logic [CNTW-1:0]  on_q, on_d;
    logic [CNTW-1:0]  off_q, off_d;
    logic [CTRLW-1:0] last_q, last_d;
    logic [CTRLW-1:0] ctrl_q, ctrl_d;
    logic             err_en_q, busy_q, done_q, aborted_q, cfg_err_q;
    logic             done_d, aborted_d, cfg_err_d;
    logic             proceed;

    // Next-state, counters and pulse outputs; outputs are registered from state_d.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        on_d      = on_q;
        off_d     = off_q;
        last_d    = last_q;
        ctrl_d    = ctrl_q;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        cfg_err_d = 1'b0;
        proceed   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    if ((first_ctrl <= last_ctrl) && (on_cycles != '0)) begin
                        on_d    = on_cycles;
                        off_d   = off_cycles;
                        last_d  = last_ctrl;
                        ctrl_d  = first_ctrl;
                        cnt_d   = on_cycles;
                        state_d = StInject;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            StInject: begin
                if (abort) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNTW'(1)) begin
                    if (off_q != '0) begin
                        state_d = StGap;
                        cnt_d   = off_q;
                    end else begin
                        proceed = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            StGap: begin
                if (abort) begin
                    state_d   = StIdle;
                    cnt_d     = '0;
                    aborted_d = 1'b1;
                end else if (cnt_q == CNTW'(1)) begin
                    proceed = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = '0;
            end
        endcase

        // Equality terminates the sweep, so the top index never wraps to zero.
        if (proceed) begin
            if (ctrl_q == last_q) begin
                state_d = StIdle;
                cnt_d   = '0;
                done_d  = 1'b1;
            end else begin
                ctrl_d  = ctrl_q + CTRLW'(1);
                cnt_d   = on_q;
                state_d = StInject;
            end
        end
    end

    // State, configuration and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            on_q      <= '0;
            off_q     <= '0;
            last_q    <= '0;
            ctrl_q    <= '0;
            err_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            on_q      <= on_d;
            off_q     <= off_d;
            last_q    <= last_d;
            ctrl_q    <= ctrl_d;
            err_en_q  <= (state_d == StInject);
            busy_q    <= (state_d != StIdle);
            done_q    <= done_d;
            aborted_q <= aborted_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign err_en   = err_en_q;
    assign err_ctrl = ctrl_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign aborted  = aborted_q;
    assign cfg_err  = cfg_err_q;

endmodule

// File: tb/tb_err_campaign_sequencer.sv
// Self-checking bench for err_campaign_sequencer: each campaign is checked cycle by
// cycle against an expected trace built from the sweep rules.
module tb_err_campaign_sequencer;

    localparam int CTRLW = 8;
    localparam int CNTW  = 16;

    logic             clk = 1'b0;
    logic             rst, start, abort;
    logic [CTRLW-1:0] first_ctrl, last_ctrl;
    logic [CNTW-1:0]  on_cycles, off_cycles;
    logic             err_en, busy, done, aborted, cfg_err;
    logic [CTRLW-1:0] err_ctrl;

    // {err_en, err_ctrl, busy, done, aborted, cfg_err}
    typedef logic [CTRLW+4:0] obs_t;

    int n_cmp = 0;
    int n_err = 0;
    int model_ctrl = 0;

    always #5 clk = ~clk;

    err_campaign_sequencer #(.CTRLW(CTRLW), .CNTW(CNTW)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .abort     (abort),
        .first_ctrl(first_ctrl),
        .last_ctrl (last_ctrl),
        .on_cycles (on_cycles),
        .off_cycles(off_cycles),
        .err_en    (err_en),
        .err_ctrl  (err_ctrl),
        .busy      (busy),
        .done      (done),
        .aborted   (aborted),
        .cfg_err   (cfg_err)
    );

    function automatic obs_t observe();
        return {err_en, err_ctrl, busy, done, aborted, cfg_err};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; abort = 1'b1; start = 1'b1;
        first_ctrl = 8'd1; last_ctrl = 8'd2; on_cycles = 16'd1; off_cycles = 16'd0;
        step();
        step();
        n_cmp++;
        if (observe() !== '0) begin
            n_err++;
            $display("FAIL reset: got %h expected %h", observe(), obs_t'(0));
        end
        rst = 1'b0; abort = 1'b0; start = 1'b0;
        model_ctrl = 0;
        step();
    endtask

    // Launch a campaign and compare every cycle against the expected trace.
    // abort_at < 0 means no abort; otherwise abort is raised during that trace cycle.
    task automatic test_campaign(input string name, input int first, input int last,
                                 input int on, input int off, input int abort_at);
        obs_t exp_q[$];
        obs_t e;
        for (int i = first; i <= last; i++) begin
            for (int c = 0; c < on; c++)  exp_q.push_back({1'b1, CTRLW'(i), 1'b1, 3'b000});
            for (int c = 0; c < off; c++) exp_q.push_back({1'b0, CTRLW'(i), 1'b1, 3'b000});
        end
        exp_q.push_back({1'b0, CTRLW'(last), 1'b0, 3'b100});
        if (abort_at >= 0 && abort_at < exp_q.size() - 1) begin
            e = exp_q[abort_at];
            while (exp_q.size() > abort_at + 1) void'(exp_q.pop_back());
            exp_q.push_back({1'b0, e[CTRLW+3:4], 1'b0, 3'b010});
        end

        first_ctrl = CTRLW'(first); last_ctrl = CTRLW'(last);
        on_cycles = CNTW'(on); off_cycles = CNTW'(off);
        start = 1'b1;
        step();
        for (int k = 0; k < exp_q.size(); k++) begin
            n_cmp++;
            if (observe() !== exp_q[k]) begin
                n_err++;
                $display("FAIL %s cycle %0d: got %h expected %h", name, k, observe(), exp_q[k]);
            end
            // Scrambled config and stray starts while busy must be ignored.
            first_ctrl = 8'($urandom); last_ctrl = 8'($urandom);
            on_cycles = 16'($urandom_range(0, 3)); off_cycles = 16'($urandom_range(0, 3));
            start = (k < exp_q.size() - 1) ? 1'($urandom_range(0, 1)) : 1'b0;
            abort = (k == abort_at);
            step();
        end
        start = 1'b0; abort = 1'b0;
        e = exp_q[exp_q.size() - 1];
        model_ctrl = int'(e[CTRLW+3:4]);
        n_cmp++;
        if (observe() !== {1'b0, e[CTRLW+3:4], 4'b0000}) begin
            n_err++;
            $display("FAIL %s settle: got %h expected %h", name, observe(),
                     {1'b0, e[CTRLW+3:4], 4'b0000});
        end
    endtask

    task automatic test_cfg_err();
        int rows[2][4] = '{'{5, 3, 2, 1}, '{3, 5, 0, 1}};
        for (int r = 0; r < 2; r++) begin
            first_ctrl = CTRLW'(rows[r][0]); last_ctrl = CTRLW'(rows[r][1]);
            on_cycles = CNTW'(rows[r][2]); off_cycles = CNTW'(rows[r][3]);
            start = 1'b1;
            step();
            start = 1'b0;
            n_cmp++;
            if (observe() !== {1'b0, CTRLW'(model_ctrl), 4'b0001}) begin
                n_err++;
                $display("FAIL cfg_err row %0d pulse: got %h expected %h", r, observe(),
                         {1'b0, CTRLW'(model_ctrl), 4'b0001});
            end
            step();
            n_cmp++;
            if (observe() !== {1'b0, CTRLW'(model_ctrl), 4'b0000}) begin
                n_err++;
                $display("FAIL cfg_err row %0d after: got %h expected %h", r, observe(),
                         {1'b0, CTRLW'(model_ctrl), 4'b0000});
            end
        end
    endtask

    task automatic test_reset_mid_gap();
        first_ctrl = 8'd3; last_ctrl = 8'd5; on_cycles = 16'd2; off_cycles = 16'd1;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        n_cmp++;
        if (observe() !== {1'b0, 8'd3, 4'b1000}) begin
            n_err++;
            $display("FAIL reset_mid_gap in_gap: got %h expected %h", observe(),
                     {1'b0, 8'd3, 4'b1000});
        end
        rst = 1'b1; start = 1'b1; abort = 1'b1;
        step();
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        n_cmp++;
        if (observe() !== '0) begin
            n_err++;
            $display("FAIL reset_mid_gap reset: got %h expected %h", observe(), obs_t'(0));
        end
        model_ctrl = 0;
        test_campaign("reset_mid_gap_rerun", 3, 5, 2, 1, -1);
    endtask

    task automatic test_random();
        for (int n = 0; n < 25; n++) begin
            int f, l, on, off, len, ab;
            f   = $urandom_range(0, 255);
            l   = f + $urandom_range(0, (255 - f) < 3 ? (255 - f) : 3);
            on  = $urandom_range(1, 3);
            off = $urandom_range(0, 2);
            len = (l - f + 1) * (on + off) + 1;
            ab  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, len - 1) : -1;
            test_campaign("random", f, l, on, off, ab);
        end
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        first_ctrl = '0; last_ctrl = '0; on_cycles = '0; off_cycles = '0;
        #1;
        test_reset();
        test_campaign("basic_3_5", 3, 5, 2, 1, -1);
        test_campaign("single_7", 7, 7, 1, 0, -1);
        test_cfg_err();
        test_campaign("top_254_255", 254, 255, 1, 0, -1);
        test_campaign("abort_second_window", 3, 5, 2, 1, 3);
        test_campaign("abort_final_cycle", 3, 5, 2, 1, 8);
        test_campaign("abort_in_idle", 2, 2, 1, 1, 2);
        test_reset_mid_gap();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
